// File: rtl/conv_pkg.sv
// ============================================================================
// Module      : conv_pkg
// Description : Shared constants and types for the K=3 rate-1/2 convolutional
//               encoder and its companion Viterbi decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package conv_pkg;

    localparam int SYM_W = 2;
    localparam int K     = 3;

    localparam logic [K-1:0] G1_DEFAULT = 3'b111;
    localparam logic [K-1:0] G2_DEFAULT = 3'b101;

    // Trellis state {u_k-1, u_k-2}, also the decoder's state index.
    typedef logic [K-2:0] trellis_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_TAIL1 = 2'd2,
        ST_TAIL2 = 2'd3
    } enc_state_t;

endpackage

`default_nettype wire

// File: rtl/conv_sym_gen.sv
// ============================================================================
// Module      : conv_sym_gen
// Description : Combinational branch-label generator: {u, sr} -> {g1, g2} and
//               the successor trellis state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_sym_gen
    import conv_pkg::*;
#(
    parameter logic [K-1:0] G1 = G1_DEFAULT,
    parameter logic [K-1:0] G2 = G2_DEFAULT
) (
    input  logic             u,
    input  trellis_t         sr,
    output logic [SYM_W-1:0] sym,
    output trellis_t         sr_next
);

    logic [K-1:0] w_taps;

    assign w_taps  = {u, sr};
    assign sym     = {^(G1 & w_taps), ^(G2 & w_taps)};
    assign sr_next = {u, sr[K-2:1]};

endmodule

`default_nettype wire

// File: rtl/conv_encoder.sv
// ============================================================================
// Module      : conv_encoder
// Description : Framed rate-1/2 K=3 convolutional encoder, one registered
//               symbol per info bit. Define CONV_ENC_TAIL_EN to append two
//               zero tail symbols per frame (trellis ends in state 00).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_encoder
    import conv_pkg::*;
#(
    parameter logic [K-1:0] G1    = G1_DEFAULT,
    parameter logic [K-1:0] G2    = G2_DEFAULT,
    parameter int           CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SYM_W-1:0] out_sym,
    output logic             out_last,
    output logic             out_tail,
    output logic             busy,
    output logic [CNT_W-1:0] bit_cnt
);

`ifdef CONV_ENC_TAIL_EN
    localparam bit         c_TAIL_EN      = 1'b1;
    localparam enc_state_t c_ST_AFTER_LAST = ST_TAIL1;
`else
    localparam bit         c_TAIL_EN      = 1'b0;
    localparam enc_state_t c_ST_AFTER_LAST = ST_IDLE;
`endif

    enc_state_t       r_state;
    enc_state_t       w_state_next;
    trellis_t         r_sr;
    trellis_t         w_sr_next;
    logic             r_out_valid;
    logic [SYM_W-1:0] r_out_sym;
    logic [SYM_W-1:0] w_sym;
    logic             r_out_last;
    logic             r_out_tail;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             w_slot_free;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_tail_emit;
    logic             w_tail_final;
    logic             w_u;

    assign w_slot_free = !r_out_valid || out_ready;
    assign w_accept    = in_valid && w_in_ready;
    // Tail symbols encode u=0; a non-accepted cycle also presents 0.
    assign w_u         = w_accept ? in_bit : 1'b0;

    conv_sym_gen #(
        .G1 (G1),
        .G2 (G2)
    ) u_sym_gen (
        .u       (w_u),
        .sr      (r_sr),
        .sym     (w_sym),
        .sr_next (w_sr_next)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DATA: begin
                if (w_accept) begin
                    w_state_next = in_last ? c_ST_AFTER_LAST : ST_DATA;
                end
            end
`ifdef CONV_ENC_TAIL_EN
            ST_TAIL1: if (w_slot_free) w_state_next = ST_TAIL2;
            ST_TAIL2: if (w_slot_free) w_state_next = ST_IDLE;
`endif
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready   = 1'b0;
        w_tail_emit  = 1'b0;
        w_tail_final = 1'b0;
        if (rst) begin
            case (r_state)
                ST_IDLE, ST_DATA: w_in_ready = w_slot_free;
`ifdef CONV_ENC_TAIL_EN
                ST_TAIL1: w_tail_emit = w_slot_free;
                ST_TAIL2: begin
                    w_tail_emit  = w_slot_free;
                    w_tail_final = w_slot_free;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sr        <= '0;
            r_out_valid <= 1'b0;
            r_out_sym   <= '0;
            r_out_last  <= 1'b0;
            r_out_tail  <= 1'b0;
        end else begin
            if (w_accept) begin
                // Without a tail flush the next frame must still start at 00.
                r_sr <= (in_last && !c_TAIL_EN) ? '0 : w_sr_next;
            end else if (w_tail_emit) begin
                r_sr <= w_tail_final ? '0 : w_sr_next;
            end

            if (w_accept || w_tail_emit) begin
                r_out_valid <= 1'b1;
                r_out_sym   <= w_sym;
                r_out_last  <= w_accept ? (in_last && !c_TAIL_EN) : w_tail_final;
                r_out_tail  <= w_tail_emit;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bit_cnt <= '0;
        end else if (w_state_next == ST_IDLE && (r_state != ST_IDLE || w_accept)) begin
            r_bit_cnt <= '0;
        end else if (w_accept && r_bit_cnt != {CNT_W{1'b1}}) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_sym   = r_out_sym;
    assign out_last  = r_out_last;
    assign out_tail  = r_out_tail;
    assign busy      = (r_state != ST_IDLE) || r_out_valid;
    assign bit_cnt   = r_bit_cnt;

endmodule

`default_nettype wire

// File: tb/tb_conv_encoder.sv
// ============================================================================
// Module      : tb_conv_encoder
// Description : Self-checking bench for conv_encoder against a frame-level
//               reference model; honours CONV_ENC_TAIL_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv_encoder;

`ifdef CONV_ENC_TAIL_EN
    localparam bit TAIL = 1'b1;
`else
    localparam bit TAIL = 1'b0;
`endif

    typedef struct { logic bit_v; logic last_v; } ib_t;
    typedef struct { logic [1:0] sym; logic last; logic tail; } sym_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_bit = 1'b0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [1:0] out_sym;
    logic       out_last;
    logic       out_tail;
    logic       busy;
    logic [7:0] bit_cnt;

    int total = 0;
    int bad   = 0;

    ib_t  in_q[$];
    sym_t exp_q[$];
    int   tails_left = 0;
    int   cnt_m      = 0;
    logic prev_hold  = 1'b0;
    logic [3:0] prev_word = '0;
    int   gaps    = 0;
    int   lasts   = 0;
    logic started = 1'b0;

    conv_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bit    (in_bit),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sym   (out_sym),
        .out_last  (out_last),
        .out_tail  (out_tail),
        .busy      (busy),
        .bit_cnt   (bit_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: g1 = u^u1^u2, g2 = u^u2, trellis starts at 00 every frame.
    task automatic push_frame(input int n, input logic [7:0] bits);
        logic u1, u2, u;
        u1 = 1'b0;
        u2 = 1'b0;
        for (int i = 0; i < n; i++) begin
            u = bits[i];
            in_q.push_back('{bit_v: u, last_v: (i == n - 1)});
            exp_q.push_back('{sym: {u ^ u1 ^ u2, u ^ u2}, last: (!TAIL && i == n - 1), tail: 1'b0});
            u2 = u1;
            u1 = u;
        end
        if (TAIL) begin
            for (int j = 0; j < 2; j++) begin
                exp_q.push_back('{sym: {u1 ^ u2, u2}, last: (j == 1), tail: 1'b1});
                u2 = u1;
                u1 = 1'b0;
            end
        end
    endtask

    // rmode: 0 ready high, 1 toggling, 2 random; vmode: 0 valid held, 1 random gaps
    task automatic step(input int rmode, input int vmode);
        logic slot;
        sym_t e;
        ib_t  f;
        @(negedge clk);
        case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
        in_valid = (in_q.size() > 0) && (vmode == 0 || $urandom_range(0, 2) != 0);
        if (in_valid) begin
            in_bit  = in_q[0].bit_v;
            in_last = in_q[0].last_v;
        end else begin
            in_bit  = 1'($urandom);
            in_last = 1'($urandom);
        end
        #1;
        slot = !out_valid || out_ready;
        chk("in_ready", in_ready, (tails_left == 0) ? slot : 1'b0);
        chk("bit_cnt", bit_cnt, cnt_m);
        if (prev_hold) chk("hold", {out_valid, out_sym, out_last, out_tail}, {1'b1, prev_word});
        if (started && !out_valid && exp_q.size() > 0) gaps++;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("extra_sym", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("sym_last_tail", {out_sym, out_last, out_tail}, {e.sym, e.last, e.tail});
                if (out_last) lasts++;
            end
            started = 1'b1;
        end
        if (tails_left > 0 && slot) begin
            tails_left--;
            if (tails_left == 0) cnt_m = 0;
        end
        if (in_valid && in_ready && in_q.size() > 0) begin
            f = in_q.pop_front();
            if (f.last_v && !TAIL) begin
                cnt_m = 0;
            end else begin
                if (cnt_m < 255) cnt_m++;
                if (f.last_v) tails_left = 2;
            end
        end
        prev_hold = out_valid && !out_ready;
        prev_word = {out_sym, out_last, out_tail};
    endtask

    task automatic run(input int rmode, input int vmode);
        int n;
        n = 0;
        while ((in_q.size() > 0 || exp_q.size() > 0) && n < 2000) begin
            step(rmode, vmode);
            n++;
        end
        chk("run_timeout", (n < 2000), 1);
        @(negedge clk);
        #1;
        chk("idle_busy", {busy, out_valid}, 0);
        chk("idle_cnt", bit_cnt, 0);
        prev_hold = 1'b0;
    endtask

    // Caller positions this just after a negedge; holds reset over one edge.
    task automatic do_reset();
        rst       = 1'b0;
        in_valid  = 1'b1;
        in_bit    = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 0);
        @(negedge clk);
        #1;
        chk("rst_state", {out_valid, busy, out_sym, out_last, out_tail, bit_cnt}, 0);
        rst      = 1'b1;
        in_valid = 1'b0;
        in_q.delete();
        exp_q.delete();
        tails_left = 0;
        cnt_m      = 0;
        prev_hold  = 1'b0;
    endtask

    initial begin
        int n;
        @(negedge clk);
        do_reset();

        push_frame(4, 8'b0000_1101);
        run(0, 0);

        push_frame(4, 8'b0000_1101);
        run(1, 0);

        push_frame(1, 8'b0000_0001);
        run(0, 0);

        gaps    = 0;
        lasts   = 0;
        started = 1'b0;
        push_frame(1, 8'b0000_0001);
        push_frame(2, 8'b0000_0000);
        run(0, 0);
        chk("b2b_gaps", gaps, 0);
        chk("b2b_lasts", lasts, 2);

        // Reset while the output register holds a symbol (TAIL1 when tails are on).
        push_frame(4, 8'b0000_1101);
        n = 0;
        while (in_q.size() > 0 && n < 100) begin
            step(0, 0);
            n++;
        end
        @(negedge clk);
        #1;
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_cnt", bit_cnt, cnt_m);
        do_reset();
        push_frame(1, 8'b0000_0001);
        run(0, 0);

        for (int k = 0; k < 40; k++) begin
            push_frame($urandom_range(1, 6), 8'($urandom));
            if ($urandom_range(0, 2) == 0) push_frame($urandom_range(1, 6), 8'($urandom));
            run(2, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
